// File: rtl/program_counter_if.sv
// Bus bundle for the program-counter stage.
//   slave  : the PC stage itself (takes the control and next-address inputs, drives the PC and status)
//   master : whoever drives the PC stage (branch stage, decoder, pushbutton)
// Inputs : NovoEndereco, Halt, InputReq, Confirm (raw, active-low, async),
//          Stall, SaveContext, RestoreContext
// Outputs: PCAtual, ContextPC, Waiting, Halted, Enable
interface program_counter_if #(parameter int ADDR_WIDTH = 11);
  logic [ADDR_WIDTH-1:0] NovoEndereco;
  logic                  Halt;
  logic                  InputReq;
  logic                  Confirm;
  logic                  Stall;
  logic                  SaveContext;
  logic                  RestoreContext;
  logic [ADDR_WIDTH-1:0] PCAtual;
  logic [ADDR_WIDTH-1:0] ContextPC;
  logic                  Waiting;
  logic                  Halted;
  logic                  Enable;

  modport master (
    output NovoEndereco, Halt, InputReq, Confirm, Stall, SaveContext, RestoreContext,
    input  PCAtual, ContextPC, Waiting, Halted, Enable
  );

  modport slave (
    input  NovoEndereco, Halt, InputReq, Confirm, Stall, SaveContext, RestoreContext,
    output PCAtual, ContextPC, Waiting, Halted, Enable
  );
endinterface

// File: rtl/program_counter.sv
// Registered program counter of the single-cycle core.
// Loads NovoEndereco every edge, freezes on Stall / Halt / InputReq, keeps a
// saved-context return address, and releases input waits on a debounced press
// of the active-low Confirm pushbutton.
// Ports:
//   clock - rising-edge system clock
//   reset - asynchronous, active-low
//   bus   - program_counter_if.slave (see interface header for signal list)
module program_counter #(
  parameter int                    ADDR_WIDTH      = 11,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR      = '0,
  parameter int                    DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  program_counter_if.slave  bus
);

  typedef enum logic [1:0] {RUN, WAIT_IN, HALT} state_t;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] ctx;
  logic                  waiting;
  logic                  halted;

  logic [1:0]            sync;   // sync[1] is the synchronized button level
  logic                  level;  // accepted (debounced) level, idle high
  logic [CW-1:0]         cnt;
  logic                  press;  // one-cycle pulse on accepted 1->0

  // Confirm synchronizer and debouncer. A level is accepted only after
  // DEBOUNCE_CYCLES consecutive samples disagree with the current one; any
  // agreeing sample clears the run, so short glitches never get through.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], bus.Confirm};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          cnt   <= '0;
          press <= level;  // old level high means this is a press
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Control FSM. Presses arriving outside WAIT_IN are simply dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      pc      <= RESET_ADDR;
      ctx     <= '0;
      waiting <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.Halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (!bus.Stall) begin
            // Save uses the old ctx on the right-hand side of restore below,
            // so save+restore together swaps.
            if (bus.SaveContext) ctx <= pc + 1'b1;
            if (bus.InputReq) begin
              state   <= WAIT_IN;
              waiting <= 1'b1;
            end else if (bus.RestoreContext) begin
              pc <= ctx;
            end else begin
              pc <= bus.NovoEndereco;
            end
          end
        end
        WAIT_IN: begin
          if (press) begin
            pc      <= bus.NovoEndereco;
            state   <= RUN;
            waiting <= 1'b0;
          end
        end
        HALT: ;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.PCAtual   = pc;
  assign bus.ContextPC = ctx;
  assign bus.Waiting   = waiting;
  assign bus.Halted    = halted;
  assign bus.Enable    = (state == RUN) && !bus.Stall && !bus.Halt && !bus.InputReq;

endmodule
